// File: rtl/scan_chain_tester.sv
// ---------------------------------------------------------------------------
// scan_chain_tester
//   Loads a CHAIN_LEN-bit pattern into one scan chain, then shifts it back out
//   and compares every unloaded bit against the pattern. Reports pass/fail,
//   the number of mismatching bits and the unload index of the first mismatch.
//
// Ports
//   sclk            scan clock, all state updates on posedge
//   rst             asynchronous active-high reset
//   start           request a test (accepted only in IDLE, not during aborted)
//   pattern         pattern to load, captured when start is accepted
//   abort           cancel a test in LOAD or UNLOAD
//   so              scan out of the chain (chain MSB)
//   se, si          scan enable / scan in driven into the chain
//   busy            high in LOAD, UNLOAD and DONE
//   done            one-cycle result-valid pulse (DONE state)
//   aborted         one-cycle pulse after a cancelled test
//   pass            fail_cnt was zero at the end of the unload
//   fail_cnt        number of mismatching unloaded bits
//   first_fail_idx  unload index of the first mismatch
//   first_fail_vld  first_fail_idx is meaningful
//   state_dbg       current FSM state, for observation only
//
// Handshake: start is a level sampled at posedge; it is consumed only when the
// FSM is in IDLE and no aborted pulse is showing, otherwise it is dropped (no
// queueing). done and aborted are single-cycle pulses with no back-pressure.
// ---------------------------------------------------------------------------
module scan_chain_tester #(
    parameter int CHAIN_LEN = 8,
    parameter bit FILL_BIT  = 1'b0,
    localparam int CW       = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 abort,
    input  logic                 so,
    output logic                 se,
    output logic                 si,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 pass,
    output logic [CW-1:0]        fail_cnt,
    output logic [CW-1:0]        first_fail_idx,
    output logic                 first_fail_vld,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] shreg;
    // Expected-data copy; shifted left during UNLOAD so its MSB always
    // holds the bit expected on so at the current unload index.
    logic [CHAIN_LEN-1:0] exp;

    logic                 accept;
    logic                 abort_hit;
    logic                 last_bit;
    logic                 mismatch;
    logic [CW-1:0]        fail_cnt_nxt;

    assign state_dbg    = state;
    assign accept       = (state == IDLE) && start && !aborted;
    assign abort_hit    = abort && ((state == LOAD) || (state == UNLOAD));
    assign last_bit     = (cnt == CW'(CHAIN_LEN - 1));
    assign mismatch     = (state == UNLOAD) && (so != exp[CHAIN_LEN-1]);
    assign fail_cnt_nxt = fail_cnt + CW'(mismatch);

    // State register
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and chain-facing outputs
    always_comb begin
        state_nxt = state;
        se        = 1'b0;
        si        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                se   = 1'b1;
                si   = shreg[CHAIN_LEN-1];
                busy = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                se   = 1'b1;
                si   = FILL_BIT;
                busy = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            shreg          <= '0;
            exp            <= '0;
            aborted        <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (accept) begin
                shreg          <= pattern;
                exp            <= pattern;
                cnt            <= '0;
                pass           <= 1'b0;
                fail_cnt       <= '0;
                first_fail_idx <= '0;
                first_fail_vld <= 1'b0;
            end else if (abort_hit) begin
                // A cancelled test leaves nothing behind but the pulse.
                aborted        <= 1'b1;
                cnt            <= '0;
                shreg          <= '0;
                exp            <= '0;
                pass           <= 1'b0;
                fail_cnt       <= '0;
                first_fail_idx <= '0;
                first_fail_vld <= 1'b0;
            end else if (state == LOAD) begin
                shreg <= {shreg[CHAIN_LEN-2:0], 1'b0};
                cnt   <= last_bit ? '0 : cnt + CW'(1);
            end else if (state == UNLOAD) begin
                exp      <= {exp[CHAIN_LEN-2:0], 1'b0};
                cnt      <= last_bit ? '0 : cnt + CW'(1);
                fail_cnt <= fail_cnt_nxt;
                if (mismatch && !first_fail_vld) begin
                    first_fail_idx <= cnt;
                    first_fail_vld <= 1'b1;
                end
                // pass is settled on the final compare so it is valid in DONE
                if (last_bit) pass <= (fail_cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_tester.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_tester
//   Directed bench for scan_chain_tester with CHAIN_LEN=8. A behavioural scan
//   chain sits between se/si and so; it can hold flop 3 stuck at 0 or invert
//   so at unload index 5.
// ---------------------------------------------------------------------------
module tb_scan_chain_tester;

    localparam int N  = 8;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic sclk = 1'b0;
    logic rst;
    always #5 sclk = ~sclk;

    logic          start;
    logic [N-1:0]  pattern;
    logic          abort;
    logic          so;
    logic          se, si, busy, done, aborted, pass, first_fail_vld;
    logic [CW-1:0] fail_cnt, first_fail_idx;
    logic [1:0]    state_dbg;

    scan_chain_tester #(.CHAIN_LEN(N), .FILL_BIT(1'b0)) dut (
        .sclk          (sclk),
        .rst           (rst),
        .start         (start),
        .pattern       (pattern),
        .abort         (abort),
        .so            (so),
        .se            (se),
        .si            (si),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .pass          (pass),
        .fail_cnt      (fail_cnt),
        .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld),
        .state_dbg     (state_dbg)
    );

    // ---------------- golden chain model ----------------
    logic [N-1:0] q = '0;
    logic [N-1:0] qn;
    int           se_cnt = 0;
    logic         stuck3 = 1'b0;
    logic         inv5   = 1'b0;

    always @(posedge sclk) begin
        if (se) begin
            qn = {q[N-2:0], si};
            if (stuck3) qn[3] = 1'b0;
            q      <= qn;
            se_cnt <= se_cnt + 1;
        end else begin
            se_cnt <= 0;
        end
    end

    // se_cnt 8..15 are unload indices 0..7
    assign so = q[N-1] ^ (inv5 && (se_cnt == N + 5));

    // ---------------- scoreboard ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // ---------------- driver ----------------
    int           obs_se;
    int           obs_done;
    int           done_at;
    logic         obs_pass;
    logic [N-1:0] obs_si;

    // Launches one test and watches a fixed 22-cycle window (bounded).
    // poke_at >= 0 re-asserts start during that window cycle.
    task automatic run_test(input logic [N-1:0] pat, input int poke_at);
        obs_se   = 0;
        obs_done = 0;
        done_at  = -1;
        obs_pass = 1'b0;
        obs_si   = '0;
        @(negedge sclk);
        pattern = pat;
        start   = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge sclk);
            if (se) begin
                if (obs_se < N) obs_si = {obs_si[N-2:0], si};
                obs_se++;
            end
            if (done) begin
                obs_done++;
                done_at  = i;
                obs_pass = pass;
            end
            start = (i == poke_at);
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        repeat (2) @(negedge sclk);
        chk("rst_se",     se,             0);
        chk("rst_busy",   busy,           0);
        chk("rst_pass",   pass,           0);
        chk("rst_fcnt",   fail_cnt,       0);
        chk("rst_ffvld",  first_fail_vld, 0);
        chk("rst_state",  state_dbg,      0);
        rst = 1'b0;
        @(negedge sclk);

        // 1: clean chain, A5
        run_test(8'hA5, -1);
        exp_q.push_back(8'b1); exp_q.push_back(8'b0); exp_q.push_back(8'b1); exp_q.push_back(8'b0);
        exp_q.push_back(8'b0); exp_q.push_back(8'b1); exp_q.push_back(8'b0); exp_q.push_back(8'b1);
        for (int b = N - 1; b >= 0; b--) chk("t1_si_bit", obs_si[b], exp_q.pop_front());
        chk("t1_se_cycles", obs_se,   16);
        chk("t1_done_cnt",  obs_done, 1);
        chk("t1_done_at",   done_at,  16);
        chk("t1_pass",      obs_pass, 1);
        chk("t1_fcnt",      fail_cnt, 0);
        chk("t1_ffvld",     first_fail_vld, 0);
        chk("t1_hold_pass", pass,     1);

        // 2: q[3] stuck-at-0, FF
        stuck3 = 1'b1;
        run_test(8'hFF, -1);
        chk("t2_done_cnt", obs_done,       1);
        chk("t2_pass",     obs_pass,       0);
        chk("t2_fcnt",     fail_cnt,       8);
        chk("t2_ffidx",    first_fail_idx, 0);
        chk("t2_ffvld",    first_fail_vld, 1);

        // 3: same fault, 00 does not detect it
        run_test(8'h00, -1);
        chk("t3_pass",  obs_pass,       1);
        chk("t3_fcnt",  fail_cnt,       0);
        chk("t3_ffvld", first_fail_vld, 0);
        stuck3 = 1'b0;

        // 4: so inverted at unload index 5 only
        inv5 = 1'b1;
        run_test(8'h3C, -1);
        chk("t4_pass",  obs_pass,       0);
        chk("t4_fcnt",  fail_cnt,       1);
        chk("t4_ffidx", first_fail_idx, 5);
        chk("t4_ffvld", first_fail_vld, 1);
        inv5 = 1'b0;

        // 5: abort at LOAD cnt=3, start during the aborted pulse is dropped
        @(negedge sclk);
        pattern = 8'h5A;
        start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            start = 1'b0;
        end
        chk("t5_in_load", state_dbg, 1);
        abort = 1'b1;
        @(negedge sclk);
        chk("t5_aborted",  aborted,   1);
        chk("t5_no_done",  done,      0);
        chk("t5_se_drop",  se,        0);
        chk("t5_busy",     busy,      0);
        chk("t5_fcnt_clr", fail_cnt,  0);
        chk("t5_ffv_clr",  first_fail_vld, 0);
        abort   = 1'b0;
        start   = 1'b1;
        pattern = 8'hFF;
        @(negedge sclk);
        start = 1'b0;
        chk("t5_pulse_end",   aborted,   0);
        chk("t5_start_drop",  state_dbg, 0);
        chk("t5_busy_after",  busy,      0);
        obs_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            if (done) obs_done++;
        end
        chk("t5_done_none", obs_done, 0);
        run_test(8'h81, -1);
        chk("t5b_done_cnt", obs_done, 1);
        chk("t5b_pass",     obs_pass, 1);
        chk("t5b_fcnt",     fail_cnt, 0);

        // 6a: reset mid-UNLOAD with nonzero results in flight
        stuck3 = 1'b1;
        @(negedge sclk);
        pattern = 8'hFF;
        start   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge sclk);
            start = 1'b0;
        end
        chk("t6_in_unload", state_dbg, 2);
        chk("t6_fcnt_mid",  fail_cnt,  2);
        rst = 1'b1;
        #1;
        chk("t6_rst_se",    se,             0);
        chk("t6_rst_busy",  busy,           0);
        chk("t6_rst_fcnt",  fail_cnt,       0);
        chk("t6_rst_ffvld", first_fail_vld, 0);
        chk("t6_rst_ffidx", first_fail_idx, 0);
        chk("t6_rst_state", state_dbg,      0);
        @(negedge sclk);
        rst    = 1'b0;
        stuck3 = 1'b0;
        @(negedge sclk);

        // 6b: start pulse while busy is ignored
        run_test(8'hC3, 5);
        chk("t6b_done_cnt", obs_done, 1);
        chk("t6b_done_at",  done_at,  16);
        chk("t6b_se_cyc",   obs_se,   16);
        chk("t6b_pass",     obs_pass, 1);
        chk("t6b_idle",     state_dbg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
